// File: rtl/clk_ctrl_defs.sv
// Shared encodings for the processor clock run/halt/step controller.
package clk_ctrl_defs;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RATE_4HZ  = 2'd0,
    RATE_2HZ  = 2'd1,
    RATE_1HZ  = 2'd2,
    RATE_FAST = 2'd3
  } rate_t;

  localparam int CNT_W_DEF = 26;

endpackage

// File: rtl/tc_mux.sv
// Divider terminal-count table, indexed by the latched rate select.
module tc_mux
  import clk_ctrl_defs::*;
#(
  parameter int             CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TC0 = CNT_W'(12500000),
  parameter logic [CNT_W-1:0] TC1 = CNT_W'(25000000),
  parameter logic [CNT_W-1:0] TC2 = CNT_W'(50000000),
  parameter logic [CNT_W-1:0] TC3 = CNT_W'(5000)
) (
  input  logic [1:0]       rateSel,
  output logic [CNT_W-1:0] tc
);

  always_comb begin
    tc = TC0;
    unique case (rateSel)
      RATE_4HZ:  tc = TC0;
      RATE_2HZ:  tc = TC1;
      RATE_1HZ:  tc = TC2;
      RATE_FAST: tc = TC3;
      default:   tc = TC0;
    endcase
  end

endmodule

// File: rtl/clk_run_ctrl.sv
// Run/halt/single-step controller producing a one-cycle core clock enable.
module clk_run_ctrl
  import clk_ctrl_defs::*;
#(
  parameter int             CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TC0 = CNT_W'(12500000),
  parameter logic [CNT_W-1:0] TC1 = CNT_W'(25000000),
  parameter logic [CNT_W-1:0] TC2 = CNT_W'(50000000),
  parameter logic [CNT_W-1:0] TC3 = CNT_W'(5000)
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       bp_hit,
  input  logic [1:0] rate_sel,
  output logic       tick,
  output logic       running,
  output logic [1:0] state
);

  state_t           stateQ;
  state_t           stateD;
  logic [CNT_W-1:0] countQ;
  logic [CNT_W-1:0] countD;
  logic [CNT_W-1:0] tcQ;
  logic [1:0]       rateQ;
  logic [1:0]       rateD;
  logic             tickD;
  logic             wrap;

  tc_mux #(
    .CNT_W(CNT_W),
    .TC0  (TC0),
    .TC1  (TC1),
    .TC2  (TC2),
    .TC3  (TC3)
  ) u_tcMux (
    .rateSel(rateQ),
    .tc     (tcQ)
  );

  assign wrap  = (countQ == tcQ);
  assign state = stateQ;

  always_comb begin
    stateD = ST_HALT;
    countD = '0;
    tickD  = 1'b0;
    rateD  = rateQ;
    unique case (stateQ)
      ST_HALT: begin
        rateD = rate_sel;
        if (halt_req) begin
          stateD = ST_HALT;
        end else if (step_req) begin
          stateD = ST_STEP;
          tickD  = 1'b1;
        end else if (run_req) begin
          stateD = ST_RUN;
        end
      end
      ST_RUN: begin
        // bp_hit only matters against the tick the core just consumed
        if (halt_req || (tick && bp_hit)) begin
          stateD = ST_HALT;
        end else begin
          stateD = ST_RUN;
          if (wrap) begin
            tickD = 1'b1;
            rateD = rate_sel;
          end else begin
            countD = countQ + CNT_W'(1);
          end
        end
      end
      ST_STEP: stateD = ST_HALT;
      default: stateD = ST_HALT;
    endcase
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      stateQ  <= ST_HALT;
      countQ  <= '0;
      tick    <= 1'b0;
      running <= 1'b0;
      rateQ   <= RATE_4HZ;
    end else begin
      stateQ  <= stateD;
      countQ  <= countD;
      tick    <= tickD;
      running <= (stateD == ST_RUN);
      rateQ   <= rateD;
    end
  end

endmodule
